// File: rtl/word_assembler_pkg.sv
// Shared types and helpers for the byte-to-word assembler.
package word_assembler_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {COLLECT, WRITE} state_t;

  // Never returns 0, so a depth of 1 still yields a legal 1-bit vector.
  function automatic int addr_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/word_idle_timer.sv
// Idle-cycle counter for partial words; saturates at TIMEOUT_CYCLES-1 and reports expiry.
module word_idle_timer
  import word_assembler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic armed,
  output logic expired
);

  localparam int            CW   = addr_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear || !armed) cnt <= '0;
    else if (cnt != LAST)         cnt <= cnt + 1'b1;
  end

  assign expired = armed && (cnt == LAST);

endmodule

// File: rtl/word_assembler.sv
// Collects BYTES_PER_WORD bytes into a word and writes it to the frame buffer.
// Optional partial-word timeout is built when WORD_TIMEOUT_EN is defined.
module word_assembler
  import word_assembler_pkg::*;
#(
  parameter int PIXEL_COUNT    = 172800,
  parameter int BYTES_PER_WORD = 3,
  parameter int LSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               tx_ready,
  input  logic [BYTE_W-1:0]                  data_in,
  output logic                               enable_flag,
  output logic [BYTE_W*BYTES_PER_WORD-1:0]   data_ram,
  output logic [addr_width(PIXEL_COUNT)-1:0] address,
  output logic                               frame_done,
  output logic                               timeout_flag
);

  localparam int            AW        = addr_width(PIXEL_COUNT);
  localparam int            CW        = addr_width(BYTES_PER_WORD);
  localparam logic [AW-1:0] LAST_ADDR = AW'(PIXEL_COUNT - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES_PER_WORD - 1);

  state_t                                   state;
  logic [CW-1:0]                            byte_cnt;
  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0]    shreg;
  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0]    word_nxt;
  logic [AW-1:0]                            addr_nxt;
  logic                                     last_byte;
  logic                                     expired;

  // Word as it stands after this cycle's byte lands in its slot.
  for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_slot
    localparam int POS = (LSB_FIRST != 0) ? k : BYTES_PER_WORD - 1 - k;
    assign word_nxt[POS] = (byte_cnt == CW'(k)) ? data_in : shreg[POS];
  end

  assign last_byte   = tx_ready && (byte_cnt == LAST_BYTE);
  assign enable_flag = (state == WRITE);

  // Address seen during the next cycle; advances only as a WRITE cycle ends.
  always_comb begin
    addr_nxt = address;
    if (state == WRITE) addr_nxt = (address >= LAST_ADDR) ? '0 : address + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      byte_cnt   <= '0;
      shreg      <= '0;
      address    <= '0;
      data_ram   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= last_byte ? WRITE : COLLECT;
      frame_done <= last_byte && (addr_nxt == LAST_ADDR);
      address    <= addr_nxt;
      if (tx_ready) begin
        shreg <= word_nxt;
        if (last_byte) begin
          byte_cnt <= '0;
          data_ram <= word_nxt;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (expired) begin
        byte_cnt <= '0;
      end
    end
  end

`ifdef WORD_TIMEOUT_EN
  word_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tx_ready),
    .armed   (byte_cnt != '0),
    .expired (expired)
  );

  // An arriving byte beats an expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) timeout_flag <= 1'b0;
    else       timeout_flag <= !tx_ready && expired;
  end
`else
  assign expired      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_word_assembler.sv
// Directed + random bench for word_assembler across three geometries, checked against a byte-list model.
module tb_word_assembler;

  localparam int N  = 3;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset, tx_ready;
  logic [7:0] data_in;

  logic        en0, fd0, to0;
  logic [23:0] d0;
  logic [1:0]  a0;
  logic        en1, fd1, to1;
  logic [31:0] d1;
  logic [2:0]  a1;
  logic        en2, fd2, to2;
  logic [7:0]  d2;
  logic [1:0]  a2;

  always #5 clk = ~clk;

  word_assembler #(.PIXEL_COUNT(4), .BYTES_PER_WORD(3), .LSB_FIRST(1), .TIMEOUT_CYCLES(TO)) dut0 (
    .clk(clk), .reset(reset), .tx_ready(tx_ready), .data_in(data_in),
    .enable_flag(en0), .data_ram(d0), .address(a0), .frame_done(fd0), .timeout_flag(to0));

  word_assembler #(.PIXEL_COUNT(5), .BYTES_PER_WORD(4), .LSB_FIRST(0), .TIMEOUT_CYCLES(TO)) dut1 (
    .clk(clk), .reset(reset), .tx_ready(tx_ready), .data_in(data_in),
    .enable_flag(en1), .data_ram(d1), .address(a1), .frame_done(fd1), .timeout_flag(to1));

  word_assembler #(.PIXEL_COUNT(3), .BYTES_PER_WORD(1), .LSB_FIRST(1), .TIMEOUT_CYCLES(TO)) dut2 (
    .clk(clk), .reset(reset), .tx_ready(tx_ready), .data_in(data_in),
    .enable_flag(en2), .data_ram(d2), .address(a2), .frame_done(fd2), .timeout_flag(to2));

  logic [63:0] o_data [N];
  logic [31:0] o_addr [N];
  logic        o_en   [N];
  logic        o_fd   [N];
  logic        o_to   [N];

  assign o_data[0] = 64'(d0);  assign o_addr[0] = 32'(a0);
  assign o_data[1] = 64'(d1);  assign o_addr[1] = 32'(a1);
  assign o_data[2] = 64'(d2);  assign o_addr[2] = 32'(a2);
  assign o_en[0] = en0;  assign o_fd[0] = fd0;  assign o_to[0] = to0;
  assign o_en[1] = en1;  assign o_fd[1] = fd1;  assign o_to[1] = to1;
  assign o_en[2] = en2;  assign o_fd[2] = fd2;  assign o_to[2] = to2;

  // Reference model: a list of pending bytes per instance and a count of words written.
  int          pc_m  [N] = '{4, 5, 3};
  int          bpw_m [N] = '{3, 4, 1};
  int          lsb_m [N] = '{1, 0, 1};
  logic [7:0]  qb    [N][8];
  int          qn    [N];
  int          words [N];
  int          idle  [N];
  logic [63:0] m_data[N];
  logic [31:0] m_addr[N];
  logic        m_en  [N];
  logic        m_fd  [N];
  logic        m_to  [N];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic model_edge(input logic r, input logic t, input logic [7:0] d);
    logic [63:0] w;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        qn[i] = 0; words[i] = 0; idle[i] = 0;
        m_data[i] = '0; m_addr[i] = '0; m_en[i] = 1'b0; m_fd[i] = 1'b0; m_to[i] = 1'b0;
      end else begin
        m_addr[i] = 32'(words[i] % pc_m[i]);
        m_en[i] = 1'b0; m_fd[i] = 1'b0; m_to[i] = 1'b0;
        if (t) begin
          qb[i][qn[i]] = d;
          qn[i]++;
          idle[i] = 0;
          if (qn[i] == bpw_m[i]) begin
            w = '0;
            for (int k = 0; k < bpw_m[i]; k++)
              w = w | (64'(qb[i][k]) << (8 * ((lsb_m[i] != 0) ? k : bpw_m[i] - 1 - k)));
            m_data[i] = w;
            m_en[i]   = 1'b1;
            m_fd[i]   = (m_addr[i] == 32'(pc_m[i] - 1));
            words[i]++;
            qn[i] = 0;
          end
        end else if (qn[i] > 0) begin
`ifdef WORD_TIMEOUT_EN
          if (idle[i] == TO - 1) begin
            qn[i] = 0; idle[i] = 0; m_to[i] = 1'b1;
          end else begin
            idle[i]++;
          end
`endif
        end
      end
    end
  endtask

  task automatic check(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic [7:0] d);
    reset = r; tx_ready = t; data_in = d;
    @(posedge clk);
    model_edge(r, t, d);
    #1;
    for (int i = 0; i < N; i++) begin
      check("enable_flag",  i, 64'(o_en[i]), 64'(m_en[i]));
      check("data_ram",     i, o_data[i],    m_data[i]);
      check("address",      i, 64'(o_addr[i]), 64'(m_addr[i]));
      check("frame_done",   i, 64'(o_fd[i]), 64'(m_fd[i]));
      check("timeout_flag", i, 64'(o_to[i]), 64'(m_to[i]));
    end
  endtask

  task automatic idle_n(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] pat [4];

  initial begin
    reset = 1'b1; tx_ready = 1'b0; data_in = '0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);

    // Consecutive bytes, LSB-first word and first address.
    step(1'b0, 1'b1, 8'h11); step(1'b0, 1'b1, 8'h22); step(1'b0, 1'b1, 8'h33);
    idle_n(3);

    // Spaced bytes; dut1 assembles these MSB-first.
    step(1'b1, 1'b0, 8'h00);
    pat[0] = 8'hDE; pat[1] = 8'hAD; pat[2] = 8'hBE; pat[3] = 8'hEF;
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 1'b1, pat[j]);
      idle_n(4);
    end

    // Sustained back-to-back stream.
    step(1'b1, 1'b0, 8'h00);
    for (int j = 1; j <= 6; j++) step(1'b0, 1'b1, 8'(j));
    idle_n(2);

    // Reset mid-word discards partial bytes.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h55); step(1'b0, 1'b1, 8'h66);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hAA); step(1'b0, 1'b1, 8'hBB); step(1'b0, 1'b1, 8'hCC);
    idle_n(2);

    // Reset coinciding with the last byte suppresses the write.
    step(1'b0, 1'b1, 8'h01); step(1'b0, 1'b1, 8'h02);
    step(1'b1, 1'b1, 8'h03);
    idle_n(2);

    // Enough words to wrap every frame several times.
    step(1'b1, 1'b0, 8'h00);
    for (int j = 0; j < 45; j++) step(1'b0, 1'b1, 8'($urandom));
    idle_n(2);

    // Partial word followed by a long idle gap.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h77);
    idle_n(12);
    step(1'b0, 1'b1, 8'h81); step(1'b0, 1'b1, 8'h82); step(1'b0, 1'b1, 8'h83);
    idle_n(2);

    // Random traffic with occasional long gaps and rare resets.
    for (int j = 0; j < 400; j++) begin
      if (j % 60 == 59) idle_n(TO + 1);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
    end
    idle_n(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
